// File: rtl/tcdm_bank_arbiter.sv
// Slave-side arbiter for one TCDM bank: shares the bank port between NumIn masters and routes
// in-order responses back through a tag FIFO. Define TCDM_BANK_ARB_RR_EN for round-robin, else fixed priority.
module tcdm_bank_arbiter #(
  parameter int unsigned NumIn          = 4,
  parameter int unsigned ReqDataWidth   = 32,
  parameter int unsigned RespDataWidth  = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NumIn-1:0]                       req_i,
  input  logic [NumIn-1:0][ReqDataWidth-1:0]     data_i,
  output logic [NumIn-1:0]                       gnt_o,
  output logic [NumIn-1:0]                       vld_o,
  output logic [RespDataWidth-1:0]               rdata_o,
  output logic                                   req_o,
  output logic [ReqDataWidth-1:0]                data_o,
  input  logic                                   gnt_i,
  input  logic                                   vld_i,
  input  logic [RespDataWidth-1:0]               rdata_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]    outstanding_o,
  output logic                                   err_o
);

  localparam int unsigned IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] fptr_t;

  idx_t            ptr_q;
  idx_t            winner;
  idx_t            head;
  idx_t            tag_mem [MaxOutstanding];
  fptr_t           rd_ptr_q;
  fptr_t           wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic            err_q;
  logic            full;
  logic            accept;
  logic            pop;
  logic            spurious;
  logic            found;
  int unsigned     cand;

  function automatic fptr_t fptr_inc(input fptr_t p);
    return (p == fptr_t'(MaxOutstanding - 1)) ? '0 : fptr_t'(p + 1'b1);
  endfunction

  // First asserted request at or after ptr_q, wrapping; falls back to ptr_q when nobody requests.
  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    cand   = 0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      cand = (32'(ptr_q) + i) % NumIn;
      if (!found && req_i[idx_t'(cand)]) begin
        winner = idx_t'(cand);
        found  = 1'b1;
      end
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts when vld_i is high.
  assign full     = (count_q == CntW'(MaxOutstanding)) && !vld_i;
  assign req_o    = (|req_i) && !full && !rst_i;
  assign accept   = req_o && gnt_i;
  assign data_o   = data_i[winner];
  assign head     = tag_mem[rd_ptr_q];
  assign pop      = vld_i && (count_q != '0) && !rst_i;
  assign spurious = vld_i && (count_q == '0);
  assign rdata_o  = rdata_i;

  always_comb begin
    gnt_o = '0;
    vld_o = '0;
    if (accept) gnt_o[winner] = 1'b1;
    if (pop)    vld_o[head]   = 1'b1;
  end

  assign outstanding_o = rst_i ? '0 : count_q;
  assign err_o         = rst_i ? 1'b0 : err_q;

`ifdef TCDM_BANK_ARB_RR_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (winner == idx_t'(NumIn - 1)) ? '0 : idx_t'(winner + 1'b1);
    end
  end
`else
  assign ptr_q = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) wr_ptr_q <= fptr_inc(wr_ptr_q);
      if (pop)    rd_ptr_q <= fptr_inc(rd_ptr_q);
      if (accept && !pop)      count_q <= count_q + 1'b1;
      else if (!accept && pop) count_q <= count_q - 1'b1;
      if (spurious) err_q <= 1'b1;
    end
  end

  // NOTE: tag storage has no reset; entries are only read while count_q says they are valid.
  always_ff @(posedge clk_i) begin
    if (accept) tag_mem[wr_ptr_q] <= winner;
  end

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Directed self-checking bench for tcdm_bank_arbiter (NumIn=4, MaxOutstanding=4); expectations
// follow TCDM_BANK_ARB_RR_EN when defined, fixed priority otherwise.
module tb_tcdm_bank_arbiter;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [3:0]       req_i;
  logic [3:0][31:0] data_i;
  logic [3:0]       gnt_o;
  logic [3:0]       vld_o;
  logic [31:0]      rdata_o;
  logic             req_o;
  logic [31:0]      data_o;
  logic             gnt_i;
  logic             vld_i;
  logic [31:0]      rdata_i;
  logic [2:0]       outstanding_o;
  logic             err_o;

  int checks = 0;
  int errors = 0;

`ifdef TCDM_BANK_ARB_RR_EN
  localparam int ROT_IDX [5] = '{0, 1, 2, 3, 0};
  localparam int FP_IDX  [4] = '{1, 2, 1, 2};
`else
  localparam int ROT_IDX [5] = '{0, 0, 0, 0, 0};
  localparam int FP_IDX  [4] = '{1, 1, 1, 1};
`endif

  tcdm_bank_arbiter #(
    .NumIn(4), .ReqDataWidth(32), .RespDataWidth(32), .MaxOutstanding(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .data_i(data_i), .gnt_o(gnt_o),
    .vld_o(vld_o), .rdata_o(rdata_o), .req_o(req_o), .data_o(data_o), .gnt_i(gnt_i),
    .vld_i(vld_i), .rdata_i(rdata_i), .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; req_i = '0; gnt_i = 1'b0; vld_i = 1'b0;
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    for (int m = 0; m < 4; m++) data_i[m] = 32'h100 + m;
    rdata_i = '0;

    // Outputs gated while reset is held, even with live inputs.
    rst_i = 1'b1; req_i = 4'hF; gnt_i = 1'b1; vld_i = 1'b1;
    #2;
    check("rst_req", req_o, 0);
    check("rst_gnt", gnt_o, 0);
    check("rst_vld", vld_o, 0);
    check("rst_out", outstanding_o, 0);
    tick();
    rst_i = 1'b0; req_i = '0; gnt_i = 1'b0; vld_i = 1'b0;
    #1;
    check("post_rst_req", req_o, 0);
    check("post_rst_gnt", gnt_o, 0);
    check("post_rst_vld", vld_o, 0);
    check("post_rst_out", outstanding_o, 0);
    check("post_rst_err", err_o, 0);

    // Rotation with all masters requesting, bank latency 1.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      req_i = 4'hF; gnt_i = 1'b1; vld_i = (k > 0); rdata_i = 32'hA0 + k;
      #1;
      check("rot_gnt", gnt_o, 4'b1 << ROT_IDX[k]);
      check("rot_data", data_o, 32'h100 + ROT_IDX[k]);
      check("rot_vld", vld_o, (k > 0) ? (4'b1 << ROT_IDX[(k > 0) ? k - 1 : 0]) : 4'b0);
      check("rot_out", outstanding_o, (k > 0) ? 1 : 0);
      if (k > 0) check("rot_rdata", rdata_o, 32'hA0 + k);
      tick();
    end
    req_i = '0; vld_i = 1'b1;
    #1;
    check("rot_drain_vld", vld_o, 4'b1 << ROT_IDX[4]);
    tick();
    vld_i = 1'b0;
    check("rot_drain_out", outstanding_o, 0);

    // Two requesters 1 and 2 held.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req_i = 4'b0110; gnt_i = 1'b1; vld_i = (k > 0);
      #1;
      check("fp_gnt", gnt_o, 4'b1 << FP_IDX[k]);
      check("fp_vld", vld_o, (k > 0) ? (4'b1 << FP_IDX[(k > 0) ? k - 1 : 0]) : 4'b0);
      tick();
    end
    req_i = '0; vld_i = 1'b1;
    #1;
    check("fp_drain_vld", vld_o, 4'b1 << FP_IDX[3]);
    tick();
    vld_i = 1'b0;

    // Fill the FIFO, stall, then pop+push in one cycle.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req_i = 4'b1000; gnt_i = 1'b1; vld_i = 1'b0;
      #1;
      check("fill_gnt", gnt_o, 4'b1000);
      tick();
    end
    check("full_out", outstanding_o, 4);
    #1;
    check("full_req", req_o, 0);
    check("full_gnt", gnt_o, 0);
    tick();
    check("full_hold_out", outstanding_o, 4);
    vld_i = 1'b1; rdata_i = 32'h55;
    #1;
    check("full_pp_req", req_o, 1);
    check("full_pp_gnt", gnt_o, 4'b1000);
    check("full_pp_vld", vld_o, 4'b1000);
    check("full_pp_rdata", rdata_o, 32'h55);
    tick();
    check("full_pp_out", outstanding_o, 4);
    req_i = '0;
    for (int k = 0; k < 4; k++) begin
      vld_i = 1'b1;
      #1;
      check("full_drain_vld", vld_o, 4'b1000);
      tick();
    end
    vld_i = 1'b0;
    check("full_drain_out", outstanding_o, 0);
    check("full_err", err_o, 0);

    // Routing with bank backpressure: accept 2, stall, accept 0, accept 3; responses with gaps.
    do_reset();
    req_i = 4'b0100; gnt_i = 1'b1;
    #1; check("bp_gnt0", gnt_o, 4'b0100); tick();
    req_i = 4'b0001; gnt_i = 1'b0;
    #1; check("bp_stall_req", req_o, 1); check("bp_stall_gnt", gnt_o, 0);
    check("bp_stall_data", data_o, 32'h100); tick();
    gnt_i = 1'b1;
    #1; check("bp_gnt1", gnt_o, 4'b0001); tick();
    req_i = 4'b1000; vld_i = 1'b1; rdata_i = 32'hA;
    #1; check("bp_gnt2", gnt_o, 4'b1000); check("bp_vld_a", vld_o, 4'b0100);
    check("bp_rdata_a", rdata_o, 32'hA); tick();
    req_i = '0; vld_i = 1'b0;
    #1; check("bp_gap_vld", vld_o, 0); check("bp_out3", outstanding_o, 2); tick();
    vld_i = 1'b1; rdata_i = 32'hB;
    #1; check("bp_vld_b", vld_o, 4'b0001); check("bp_rdata_b", rdata_o, 32'hB); tick();
    vld_i = 1'b0; tick();
    vld_i = 1'b1; rdata_i = 32'hC;
    #1; check("bp_vld_c", vld_o, 4'b1000); check("bp_rdata_c", rdata_o, 32'hC); tick();
    vld_i = 1'b0;
    check("bp_out_end", outstanding_o, 0);

    // Spurious response with nothing outstanding.
    vld_i = 1'b1; rdata_i = 32'hDD;
    #1; check("sp_vld", vld_o, 0); check("sp_err_before", err_o, 0); tick();
    vld_i = 1'b0;
    check("sp_err", err_o, 1);
    check("sp_out", outstanding_o, 0);
    tick(); tick();
    check("sp_err_sticky", err_o, 1);

    // Reset with three tags outstanding.
    do_reset();
    check("mr_err_clear", err_o, 0);
    for (int k = 0; k < 3; k++) begin
      req_i = 4'hF; gnt_i = 1'b1; vld_i = 1'b0;
      tick();
    end
    check("mr_out_pre", outstanding_o, 3);
    rst_i = 1'b1;
    #1; check("mr_rst_req", req_o, 0); check("mr_rst_gnt", gnt_o, 0);
    check("mr_rst_out", outstanding_o, 0); tick();
    rst_i = 1'b0; req_i = '0; gnt_i = 1'b0;
    check("mr_out", outstanding_o, 0);
    vld_i = 1'b1;
    #1; check("mr_late_vld", vld_o, 0); tick();
    vld_i = 1'b0;
    check("mr_err", err_o, 1);
    req_i = 4'hF; gnt_i = 1'b1;
    #1; check("mr_gnt_ptr0", gnt_o, 4'b0001); tick();
    req_i = '0; gnt_i = 1'b0;
    check("mr_out_after", outstanding_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcdm_bank_arbiter.md
# tcdm_bank_arbiter

Slave-side arbiter for one TCDM bank in the variable-latency interconnect. It shares a single bank port between `NumIn` requesters and grants at most one request per cycle. It keeps an in-order tag FIFO of up to `MaxOutstanding` accepted requests, and uses that FIFO to route each bank response (`vld_i`/`rdata_i`) back to the master that issued it. It sits between the per-master address decoders and the bank, one instance per bank.

## Interface
Parameters:
- `NumIn`, 4, number of requesters (≥1).
- `ReqDataWidth`, 32, width of the request payload (address, wen, be and wdata packed by the instantiator).
- `RespDataWidth`, 32, width of the read response.
- `MaxOutstanding`, 4, tag FIFO depth (≥1).

Ports:
- `clk_i` input 1: clock. One clock domain.
- `rst_i` input 1: reset. Synchronous, active-high.
- `req_i` input NumIn: request per master.
- `data_i` input NumIn×ReqDataWidth: payload per master.
- `gnt_o` output NumIn: grant per master.
- `vld_o` output NumIn: response valid per master.
- `rdata_o` output RespDataWidth: response data, broadcast to all masters.
- `req_o` output 1: request to bank.
- `data_o` output ReqDataWidth: payload of the winning master.
- `gnt_i` input 1: bank grant.
- `vld_i` input 1: bank response valid. Bank responses are in order.
- `rdata_i` input RespDataWidth: bank response data.
- `outstanding_o` output clog2(MaxOutstanding+1): number of accepted requests not yet answered.
- `err_o` output 1: sticky flag; set when `vld_i` arrives while no request is outstanding.

## Operation
- **State:**
  - priority pointer `ptr` (clog2(NumIn) bits);
  - tag FIFO of master indices (MaxOutstanding entries) with read pointer, write pointer and count;
  - `err` flag.
- **Blocking condition:** `full` = (count == MaxOutstanding) and no `vld_i` this cycle. Popping and pushing in the same cycle is allowed when count == MaxOutstanding.
- **Arbitration (combinational):**
  - The winner `w` is the first asserted `req_i` at or after `ptr`, searching with wrap-around.
  - `req_o` = |`req_i` & ~`full`.
  - `data_o` = `data_i[w]`. When `req_o`=0, `data_o` carries `data_i[ptr]`; its value is don't-care.
  - `gnt_o[w]` = `req_o` & `gnt_i`. All other `gnt_o` bits are 0.
- **Handshake:**
  - A request is accepted when `req_o` & `gnt_i`.
  - On accept, `w` is pushed into the FIFO and `ptr` ← (w+1) mod NumIn, wrapping from NumIn-1 to 0.
  - With no accept, `ptr` holds.
  - Masters hold `req_i` and `data_i` until granted. The arbiter does not lock the winner: it re-arbitrates every cycle until an accept.
- **Response:**
  - `vld_o[head]` = `vld_i` & (count≠0), where `head` is the FIFO head entry.
  - `rdata_o` = `rdata_i`, forwarded unregistered.
  - When `vld_i` and count≠0, the head is popped.
  - When `vld_i` and count==0: no `vld_o` bit asserts, FIFO state is unchanged, and `err` is set.
- **Count update:** push-only +1, pop-only −1, push and pop together unchanged. `outstanding_o` = count.
- **Reset:**
  - Resets `ptr`=0, count=0, FIFO pointers=0 and `err`=0.
  - Reset asserted mid-operation discards all outstanding tags. Responses arriving after reset therefore set `err`.
  - While `rst_i`=1, all outputs must read 0: `req_o`=0, `gnt_o`=0 and `vld_o`=0 are gated by reset.
- **Reset values of outputs (first cycle after reset):**
  - `gnt_o`=0, `vld_o`=0, `req_o`=0, `outstanding_o`=0, `err_o`=0.
  - `data_o` and `rdata_o` are don't-care.

## Timing
- Grant path is combinational: `req_i` → `req_o`, and `gnt_i` → `gnt_o` in the same cycle. Zero added latency.
- Response path is combinational: `vld_i`/`rdata_i` → `vld_o`/`rdata_o` in the same cycle.
- The bank returns `vld_i` no earlier than 1 cycle after the accept. A request accepted in cycle t cannot be answered in cycle t.
- Throughput: one accept per cycle sustained, including at count == MaxOutstanding when a pop happens in the same cycle.
- FIFO, pointer and `err` updates take effect on the rising edge following the event.

## Configuration
- `TCDM_BANK_ARB_RR_EN` defined:
  - Round-robin arbitration, with `ptr` updated on every accept as described above.
- `TCDM_BANK_ARB_RR_EN` undefined:
  - Fixed priority: lowest index wins.
  - `ptr` is held at 0 permanently.
  - All other behaviour is identical.

## Test plan
- **Round-robin rotation (RR on, NumIn=4):**
  - Stimulus: `req_i`=4'b1111 held, `gnt_i`=1, bank latency 1.
  - Required: grants in order 0,1,2,3,0 on consecutive cycles; `vld_o` follows one cycle later with the same order.
- **Fixed priority (RR off):**
  - Stimulus: `req_i`=4'b0110 held.
  - Required: master 1 is granted every cycle; master 2 is never granted.
- **Full stall (MaxOutstanding=4):**
  - Stimulus: 4 accepts with no `vld_i`.
  - Required: `outstanding_o`=4, then `req_o`=0 and no `gnt_o` while `req_i`≠0.
  - Stimulus continued: one `vld_i` while full with a request pending.
  - Required: pop and push happen in the same cycle; `outstanding_o` stays 4.
- **Response routing with bank backpressure:**
  - Stimulus: masters 2, 0, 3 accepted with `gnt_i` toggling 1,0,1,1; bank returns responses with gaps and `rdata_i`=0xA, 0xB, 0xC.
  - Required: `vld_o[2]` with `rdata_o`=0xA, then `vld_o[0]` with 0xB, then `vld_o[3]` with 0xC.
- **Spurious response:**
  - Stimulus: `vld_i`=1 with count=0.
  - Required: all `vld_o`=0, `err_o`=1 from the next cycle and remaining set until reset.
- **Reset mid-operation:**
  - Stimulus: 3 requests outstanding, `rst_i` asserted for 1 cycle.
  - Required: `outstanding_o`=0 and `ptr`=0; a subsequent `vld_i` sets `err_o`; the next request from master 0 is granted immediately.
